phase_term_gen: RTL and testbench

PHASE_TERM_GEN -- requirements
Module: phase_term_gen

---
 rtl/phase_term_pkg.sv | 35 +++
 rtl/phase_term_pipe.sv | 87 ++++++++
 rtl/phase_term_gen.sv | 141 ++++++++++++++
 tb/tb_phase_term_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/phase_term_pkg.sv
// Shared definitions for the phase term generator: FSM encoding, the
// accumulator/index/step widths and the widths of the four output terms.
package phase_term_pkg;

  localparam int IDX_W  = 12;
  localparam int STEP_W = 24;
  localparam int POS_W  = 28;
  localparam int U_W    = 8;
  localparam int SQ_W   = 16;
  localparam int CUBE_W = 24;
  localparam int A_W    = 40;
  localparam int B_W    = 38;
  localparam int C_W    = 28;
  localparam int D_W    = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Fractional weight u taken from the 12.16 position, with optional
  // round-half-up on bit 7 that saturates at 255 and never carries into idx.
  function automatic logic [U_W-1:0] pos_to_u(input logic [POS_W-1:0] pos,
                                              input logic round_en);
    logic [U_W-1:0] u_raw;
    u_raw = pos[15:8];
    if (round_en && (u_raw != 8'hFF)) begin
      return u_raw + {7'd0, pos[7]};
    end else begin
      return u_raw;
    end
  endfunction

endpackage

// File: rtl/phase_term_pipe.sv
// Three-stage stallable multiplier pipeline producing the polynomial terms
// u^3*K_A, u^2*K_B, u*K_C and K_D. A stall freezes every stage at once.
module phase_term_pipe
  import phase_term_pkg::*;
#(
  parameter logic [15:0] K_A = 16'd4096,
  parameter logic [21:0] K_B = 22'd8192,
  parameter logic [19:0] K_C = 20'd16384,
  parameter logic [17:0] K_D = 18'd65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [U_W-1:0]   i_u,
  output logic             o_valid,
  output logic             o_empty,
  output logic [IDX_W-1:0] o_idx,
  output logic [A_W-1:0]   o_a,
  output logic [B_W-1:0]   o_b,
  output logic [C_W-1:0]   o_c,
  output logic [D_W-1:0]   o_d
);

  logic              r_v1, r_v2, r_v3;
  logic [IDX_W-1:0]  r_idx1, r_idx2, r_idx3;
  logic [U_W-1:0]    r_u1;
  logic [SQ_W-1:0]   r_sq1, r_sq2;
  logic [CUBE_W-1:0] r_cube2;
  logic [C_W-1:0]    r_lin2;
  logic [A_W-1:0]    r_a3;
  logic [B_W-1:0]    r_b3;
  logic [C_W-1:0]    r_c3;
  logic [D_W-1:0]    r_d3;

  // Advance all three stages together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_idx1  <= '0;
      r_idx2  <= '0;
      r_idx3  <= '0;
      r_u1    <= '0;
      r_sq1   <= '0;
      r_sq2   <= '0;
      r_cube2 <= '0;
      r_lin2  <= '0;
      r_a3    <= '0;
      r_b3    <= '0;
      r_c3    <= '0;
      r_d3    <= '0;
    end else if (!i_stall) begin
      // S1: square
      r_v1    <= i_valid;
      r_idx1  <= i_idx;
      r_u1    <= i_u;
      r_sq1   <= {8'd0, i_u} * {8'd0, i_u};
      // S2: cube and linear term
      r_v2    <= r_v1;
      r_idx2  <= r_idx1;
      r_sq2   <= r_sq1;
      r_cube2 <= {8'd0, r_sq1} * {16'd0, r_u1};
      r_lin2  <= {20'd0, r_u1} * {8'd0, K_C};
      // S3: weighted cubic/quadratic terms and constant
      r_v3    <= r_v2;
      r_idx3  <= r_idx2;
      r_a3    <= {16'd0, r_cube2} * {24'd0, K_A};
      r_b3    <= {22'd0, r_sq2} * {16'd0, K_B};
      r_c3    <= r_lin2;
      r_d3    <= K_D;
    end else begin
      r_v1 <= r_v1;
    end
  end

  assign o_valid = r_v3;
  assign o_empty = ~(r_v1 | r_v2 | r_v3);
  assign o_idx   = r_idx3;
  assign o_a     = r_a3;
  assign o_b     = r_b3;
  assign o_c     = r_c3;
  assign o_d     = r_d3;

endmodule

// File: rtl/phase_term_gen.sv
// Phase term generator: walks a 12.16 source position across one output line
// and emits the cubic-interpolation term bundle for each sample.
// Optional build macro: PHASE_ROUND_EN rounds u on pos[7] (saturating at 255).
module phase_term_gen
  import phase_term_pkg::*;
#(
  parameter logic [15:0] K_A = 16'd4096,
  parameter logic [21:0] K_B = 22'd8192,
  parameter logic [19:0] K_C = 20'd16384,
  parameter logic [17:0] K_D = 18'd65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] step,
  input  logic [IDX_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [A_W-1:0]    out_a,
  output logic [B_W-1:0]    out_b,
  output logic [C_W-1:0]    out_c,
  output logic [D_W-1:0]    out_d
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [POS_W-1:0]  r_pos;
  logic [STEP_W-1:0] r_step;
  logic [IDX_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_issued;
  logic              w_stall;
  logic              w_accept;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_pipe_empty;
  logic              w_done;
  logic [U_W-1:0]    w_u;
  logic              w_round_en;

`ifdef PHASE_ROUND_EN
  assign w_round_en = 1'b1;
`else
  assign w_round_en = 1'b0;
`endif

  assign w_stall      = out_valid & ~out_ready;
  assign w_accept     = (r_state == ST_IDLE) & start;
  assign w_issue      = (r_state == ST_RUN) & ~w_stall;
  assign w_last_issue = w_issue & (r_issued == (r_count - 12'd1));
  assign w_u          = pos_to_u(r_pos, w_round_en);

  // Next-state and done decode for the line sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (count != 12'd0) ? ST_RUN : ST_DRAIN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last_issue) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_pipe_empty) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Position accumulator and issue counter; both hold during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos    <= '0;
      r_step   <= '0;
      r_count  <= '0;
      r_issued <= '0;
    end else if (w_accept) begin
      r_pos    <= '0;
      r_step   <= step;
      r_count  <= count;
      r_issued <= '0;
    end else if (w_issue) begin
      r_pos    <= r_pos + {4'd0, r_step};
      r_issued <= r_issued + 12'd1;
    end else begin
      r_pos    <= r_pos;
    end
  end

  phase_term_pipe #(
    .K_A(K_A),
    .K_B(K_B),
    .K_C(K_C),
    .K_D(K_D)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_issue),
    .i_stall (w_stall),
    .i_idx   (r_pos[27:16]),
    .i_u     (w_u),
    .o_valid (out_valid),
    .o_empty (w_pipe_empty),
    .o_idx   (out_idx),
    .o_a     (out_a),
    .o_b     (out_b),
    .o_c     (out_c),
    .o_d     (out_d)
  );

  assign busy = (r_state != ST_IDLE);
  assign done = w_done;

endmodule

// File: tb/tb_phase_term_gen.sv
// Self-checking bench for phase_term_gen: directed lines plus random lines
// compared against a closed-form model of position, index and terms.
module tb_phase_term_gen;

  localparam logic [63:0] KA = 64'd4096;
  localparam logic [63:0] KB = 64'd8192;
  localparam logic [63:0] KC = 64'd16384;
  localparam logic [63:0] KD = 64'd65536;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] step;
  logic [11:0] count;
  logic        busy, done, out_valid, out_ready;
  logic [11:0] out_idx;
  logic [39:0] out_a;
  logic [37:0] out_b;
  logic [27:0] out_c;
  logic [17:0] out_d;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phase_term_gen dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .count(count),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Position of sample k is simply k*step modulo 2^28.
  function automatic logic [63:0] model_pos(input logic [23:0] s, input int k);
    logic [63:0] p;
    p = 64'(k) * 64'(s);
    return p & 64'h0FFF_FFFF;
  endfunction

  function automatic logic [63:0] model_u(input logic [63:0] pos);
    logic [63:0] u;
    u = (pos >> 8) & 64'd255;
`ifdef PHASE_ROUND_EN
    if (u < 64'd255) u = u + ((pos >> 7) & 64'd1);
`endif
    return u;
  endfunction

  task automatic run_line(input logic [23:0] s, input int cnt, input int mode,
                          input bit busy_start, input bit timing);
    int k = 0;
    int cyc = 0;
    int first_v = -1;
    int last_hs = -1;
    bit got_done = 1'b0;
    bit prev_stall = 1'b0;
    logic [11:0] sv_idx;
    logic [39:0] sv_a;
    logic [37:0] sv_b;
    logic [27:0] sv_c;
    logic [17:0] sv_d;
    logic [63:0] p, u;
    @(negedge clk);
    step = s; count = 12'(cnt); start = 1'b1;
    while (!got_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy_start && cyc == 2) begin
        start = 1'b1; step = 24'($urandom); count = 12'($urandom_range(1, 50));
      end
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = !(cyc >= 6 && cyc < 11);
      if (!done) chk("busy", busy, 1);
      if (cnt == 0) chk("no_valid_zero", out_valid, 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_idx", out_idx, sv_idx);
        chk("stall_a", out_a, sv_a);
        chk("stall_b", out_b, sv_b);
        chk("stall_c", out_c, sv_c);
        chk("stall_d", out_d, sv_d);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        chk("hs_overrun", k < cnt, 1);
        p = model_pos(s, k);
        u = model_u(p);
        chk("idx", out_idx, (p >> 16) & 64'hFFF);
        chk("a", out_a, u * u * u * KA);
        chk("b", out_b, u * u * KB);
        chk("c", out_c, u * KC);
        chk("d", out_d, KD);
        k++;
        last_hs = cyc;
        if (busy_start && k == cnt) start = 1'b1;
      end
      if (done) begin
        got_done = 1'b1;
        chk("hs_count", k, cnt);
        if (cnt == 0) chk("done_zero_cyc", cyc, 1);
        else if (timing) chk("done_cyc", cyc, last_hs + 1);
      end
      prev_stall = out_valid && !out_ready;
      sv_idx = out_idx; sv_a = out_a; sv_b = out_b; sv_c = out_c; sv_d = out_d;
    end
    chk("done_seen", got_done, 1);
    if (timing && cnt > 0) chk("first_valid_cyc", first_v, 4);
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step = '0; count = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_c", out_c, 0);
    chk("rst_d", out_d, 0);
    rst = 1'b0;

    run_line(24'h010000, 4, 0, 1'b0, 1'b1);   // unit step
    run_line(24'h008000, 3, 0, 1'b0, 1'b1);   // half step, u=128 midpoint
    run_line(24'h00C000, 8, 2, 1'b0, 1'b0);   // 5-cycle stall mid-line
    run_line(24'h001234, 0, 0, 1'b0, 1'b1);   // empty line
    run_line(24'h018000, 6, 0, 1'b1, 1'b0);   // starts while busy ignored
    run_line(24'h0000FF, 2, 0, 1'b0, 1'b1);   // truncation / rounding of u
    run_line(24'hFFFFFF, 20, 1, 1'b0, 1'b0);  // idx wrap modulo 4096
    for (int i = 0; i < 12; i++) begin
      run_line(24'($urandom), $urandom_range(1, 24), 1, i[0], 1'b0);
    end

    // Reset at the second issue: everything clears, no done afterwards.
    @(negedge clk);
    step = 24'h0000FF; count = 12'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_a", out_a, 0);
    chk("mid_rst_b", out_b, 0);
    chk("mid_rst_c", out_c, 0);
    chk("mid_rst_d", out_d, 0);
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
